// File: rtl/pwm_pkg.sv
// Shared types for the PWM timer and dead-time stage: channel FSM encoding,
// gate-pair payload and default widths.
package pwm_pkg;

  localparam int unsigned DT_WIDTH_DEFAULT     = 8;
  localparam int unsigned NUM_CHANNELS_DEFAULT = 4;

  // Encoding is shared with the timer bench; keep values stable.
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LS_ON   = 3'd1,
    DT_RISE = 3'd2,
    HS_ON   = 3'd3,
    DT_FALL = 3'd4
  } dt_state_e;

  typedef struct packed {
    logic hs;
    logic ls;
  } gate_t;

  // Gate drive for a given channel state; only the two ON states drive a switch.
  function automatic gate_t gate_decode(input dt_state_e s);
    gate_t g;
    g.hs = (s == HS_ON);
    g.ls = (s == LS_ON);
    return g;
  endfunction

endpackage

// File: rtl/pwm_dt_channel.sv
// One half-bridge: dead-time FSM, its down-counter and the registered gate pair.
module pwm_dt_channel
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_pwm,
  input  logic                i_force_off,
  input  logic [DT_WIDTH-1:0] i_dt_rise,
  input  logic [DT_WIDTH-1:0] i_dt_fall,
  output logic                o_hs,
  output logic                o_ls
);

  dt_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  gate_t               gate_d;
  logic                hs_q, ls_q;

  // Next state; force-off beats everything, dead time is latched on DT entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_force_off) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = LS_ON;
        end
        LS_ON: begin
          if (i_pwm) begin
            if (i_dt_rise == '0) begin
              state_d = HS_ON;
            end else begin
              state_d = DT_RISE;
              cnt_d   = i_dt_rise - DT_WIDTH'(1);
            end
          end
        end
        DT_RISE: begin
          if (!i_pwm) begin
            state_d = LS_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = HS_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        HS_ON: begin
          if (!i_pwm) begin
            if (i_dt_fall == '0) begin
              state_d = LS_ON;
            end else begin
              state_d = DT_FALL;
              cnt_d   = i_dt_fall - DT_WIDTH'(1);
            end
          end
        end
        DT_FALL: begin
          if (i_pwm) begin
            state_d = HS_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = LS_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
    gate_d = gate_decode(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= gate_d.hs;
      ls_q    <= gate_d.ls;
    end
  end

  assign o_hs = hs_q;
  assign o_ls = ls_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time insertion for NUM_CHANNELS half-bridges with a synchronized,
// software-cleared fault latch that forces every gate off.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEFAULT,
  parameter int unsigned DT_WIDTH     = DT_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] i_pwm,
  input  logic [NUM_CHANNELS-1:0] i_en,
  input  logic [DT_WIDTH-1:0]     i_dt_rise,
  input  logic [DT_WIDTH-1:0]     i_dt_fall,
  input  logic                    i_fault,
  input  logic                    i_fault_clr,
  output logic [NUM_CHANNELS-1:0] o_hs,
  output logic [NUM_CHANNELS-1:0] o_ls,
  output logic                    o_fault
);

  logic                    fault_meta_q;
  logic                    fault_sync_q;
  logic                    fault_latched_q, fault_latched_d;
  logic [NUM_CHANNELS-1:0] force_off_c;

  // A live synchronized fault always wins over a clear request.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault_sync_q) begin
      fault_latched_d = 1'b1;
    end else if (i_fault_clr) begin
      fault_latched_d = 1'b0;
    end
    force_off_c = ~i_en | {NUM_CHANNELS{fault_latched_q}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_meta_q    <= 1'b0;
      fault_sync_q    <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      fault_meta_q    <= i_fault;
      fault_sync_q    <= fault_meta_q;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign o_fault = fault_latched_q;

  for (genvar ch = 0; ch < int'(NUM_CHANNELS); ch++) begin : g_ch
    pwm_dt_channel #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_pwm       (i_pwm[ch]),
      .i_force_off (force_off_c[ch]),
      .i_dt_rise   (i_dt_rise),
      .i_dt_fall   (i_dt_fall),
      .o_hs        (o_hs[ch]),
      .o_ls        (o_ls[ch])
    );
  end

endmodule
